sram_controller: RTL and testbench

Responder side of the MEM-stage data-memory interface. It accepts one 32-bit word read or write request at a time from the MEM stage and performs it as two 16-bit accesses on an external SRAM. It holds `ready` low until the access completes, and the pipeline uses that signal to drive its stage-wide `freeze`. It sits between the MEM stage and the board SRAM pins, replacing the single-cycle data memory.

---
 rtl/sram_controller.sv | 169 ++++++++++++++++
 tb/tb_sram_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage data-memory responder. Each 32-bit word request is
//               performed as two 16-bit accesses (low half, then high half)
//               on an external SRAM, followed by WAIT_CYCLES idle cycles.
//               'ready' stays low until the access completes and is used by
//               the pipeline as ~freeze.
//               Optional feature macro: SRAM_POSTED_WRITE_EN (posted writes
//               acknowledged in IDLE and completed in the background).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
  parameter int DATA_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_LO = 3'd1,
    S_ACC_HI = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] BASE_ADDR = DATA_BASE;
  localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic [15:0] sram_dq_out_q, sram_dq_out_d;
  logic        sram_dq_oe_q, sram_dq_oe_d;

  logic        w_req;
  logic [16:0] w_word;

  // Addresses below DATA_BASE wrap modulo 2^32 on purpose; no range check.
  assign w_req  = rd_en | wr_en;
  assign w_word = 17'((address - BASE_ADDR) >> 2);

  // Next-state, SRAM pin and ready logic; pin values are registered so they
  // are computed one cycle ahead of the phase that uses them.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    is_wr_d       = is_wr_q;
    wait_cnt_d    = wait_cnt_q;
    read_data_d   = read_data_q;
    sram_addr_d   = sram_addr_q;
    sram_we_n_d   = sram_we_n_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    ready         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Posted writes are acknowledged immediately; a write wins over a read.
        ready = POSTED ? (wr_en | ~rd_en) : ~w_req;
        if (w_req) begin
          word_d        = w_word;
          wdata_d       = write_data;
          is_wr_d       = wr_en;
          sram_addr_d   = {w_word, 1'b0};
          sram_we_n_d   = ~wr_en;
          sram_dq_oe_d  = wr_en;
          sram_dq_out_d = wr_en ? write_data[15:0] : 16'h0000;
          state_d       = S_ACC_LO;
        end
      end
      S_ACC_LO: begin
        sram_addr_d   = {word_q, 1'b1};
        sram_we_n_d   = ~is_wr_q;
        sram_dq_oe_d  = is_wr_q;
        sram_dq_out_d = is_wr_q ? wdata_q[31:16] : 16'h0000;
        if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
        state_d       = S_ACC_HI;
      end
      S_ACC_HI: begin
        sram_we_n_d   = 1'b1;
        sram_dq_oe_d  = 1'b0;
        sram_dq_out_d = 16'h0000;
        if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
        wait_cnt_d    = 4'd0;
        if (HAS_WAIT)                state_d = S_WAIT;
        else if (POSTED && is_wr_q)  state_d = S_IDLE;
        else                         state_d = S_DONE;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = 4'd0;
          state_d    = (POSTED && is_wr_q) ? S_IDLE : S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The pipeline must not freeze while reset is held.
    if (rst) ready = 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_q        <= 17'd0;
      wdata_q       <= 32'd0;
      is_wr_q       <= 1'b0;
      wait_cnt_q    <= 4'd0;
      read_data_q   <= 32'd0;
      sram_addr_q   <= 18'd0;
      sram_we_n_q   <= 1'b1;
      sram_dq_out_q <= 16'h0000;
      sram_dq_oe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      is_wr_q       <= is_wr_d;
      wait_cnt_q    <= wait_cnt_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
    end
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller. Instance 0 uses
//               WAIT_CYCLES=0, instance 1 the defaults. Each instance has its
//               own behavioural 16-bit SRAM. Honours SRAM_POSTED_WRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] address, write_data;
  logic        rd_en_v [2];
  logic        wr_en_v [2];
  logic        ready_v [2];
  logic [31:0] rdata_v [2];
  logic [17:0] saddr_v [2];
  logic        we_n_v  [2];
  logic        oe_v    [2];
  logic [15:0] dout_v  [2];
  logic [15:0] din_v   [2];

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  int tests = 0;
  int fails = 0;
  int strobe_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [17:0] lo;
    int          lat;
  } vec_t;
  vec_t vecs [7];

  sram_controller #(.DATA_BASE(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en_v[0]), .wr_en(wr_en_v[0]),
    .address(address), .write_data(write_data), .read_data(rdata_v[0]),
    .ready(ready_v[0]), .sram_addr(saddr_v[0]), .sram_we_n(we_n_v[0]),
    .sram_dq_out(dout_v[0]), .sram_dq_oe(oe_v[0]), .sram_dq_in(din_v[0])
  );

  sram_controller #(.DATA_BASE(1024), .WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en_v[1]), .wr_en(wr_en_v[1]),
    .address(address), .write_data(write_data), .read_data(rdata_v[1]),
    .ready(ready_v[1]), .sram_addr(saddr_v[1]), .sram_we_n(we_n_v[1]),
    .sram_dq_out(dout_v[1]), .sram_dq_oe(oe_v[1]), .sram_dq_in(din_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: asynchronous read, write at the end of a strobe cycle.
  always @(posedge clk) if (!we_n_v[0] && oe_v[0]) mem0[saddr_v[0]] <= dout_v[0];
  always @(posedge clk) if (!we_n_v[1] && oe_v[1]) mem1[saddr_v[1]] <= dout_v[1];
  assign din_v[0] = mem0[saddr_v[0]];
  assign din_v[1] = mem1[saddr_v[1]];

  // Strobe/enable consistency: oe only with we_n low, data zero when idle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if ((oe_v[i] != !we_n_v[i]) || (we_n_v[i] && dout_v[i] != 16'h0)) strobe_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance idx; expectations go through the scoreboard.
  task automatic do_req(input int idx, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int lat, input logic [31:0] exp_rd, input string name);
    exp_t e;
    bit   posted_wr;
    bit   seen;
    int   cyc;
    posted_wr = wr && POSTED;
    e.rdata = exp_rd;
    e.lat   = lat;
    exp_q.push_back(e);
    @(negedge clk);
    address = addr; write_data = data;
    rd_en_v[idx] = rd; wr_en_v[idx] = wr;
    #1;
    check({name, " ready@0"}, 32'(ready_v[idx]), 32'(posted_wr));
    cyc  = 0;
    seen = posted_wr;
    if (posted_wr) begin
      @(negedge clk);
      rd_en_v[idx] = 1'b0; wr_en_v[idx] = 1'b0;
      for (int k = 1; k < lat; k++) @(negedge clk);
    end else begin
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (ready_v[idx]) seen = 1'b1;
      end
    end
    rd_en_v[idx] = 1'b0; wr_en_v[idx] = 1'b0;
    e = exp_q.pop_front();
    check({name, " done"}, 32'(seen), 32'd1);
    if (!posted_wr) check({name, " latency"}, 32'(cyc), 32'(e.lat));
    check({name, " read_data"}, rdata_v[idx], e.rdata);
  endtask

  initial begin
    vecs[0] = '{rd:0, wr:1, addr:32'd1028, wdata:32'hDEADBEEF, exp_rd:32'h00000000, lo:18'd2,      lat:5};
    vecs[1] = '{rd:1, wr:0, addr:32'd1028, wdata:32'h00000000, exp_rd:32'hDEADBEEF, lo:18'd2,      lat:5};
    vecs[2] = '{rd:1, wr:1, addr:32'd1020, wdata:32'h12345678, exp_rd:32'hDEADBEEF, lo:18'h3FFFE, lat:5};
    vecs[3] = '{rd:1, wr:0, addr:32'd1020, wdata:32'h00000000, exp_rd:32'h12345678, lo:18'h3FFFE, lat:5};
    vecs[4] = '{rd:0, wr:1, addr:32'd1032, wdata:32'hCAFEF00D, exp_rd:32'h12345678, lo:18'd4,      lat:5};
    vecs[5] = '{rd:1, wr:0, addr:32'd1032, wdata:32'h00000000, exp_rd:32'hCAFEF00D, lo:18'd4,      lat:5};
    vecs[6] = '{rd:1, wr:0, addr:32'd1028, wdata:32'h00000000, exp_rd:32'hDEADBEEF, lo:18'd2,      lat:5};

    rst = 1'b1; address = 32'd0; write_data = 32'd0;
    for (int i = 0; i < 2; i++) begin rd_en_v[i] = 1'b0; wr_en_v[i] = 1'b0; end

    // Reset held two cycles, ready stays high even with a request present.
    @(negedge clk);
    check("reset ready0", 32'(ready_v[0]), 32'd1);
    rd_en_v[1] = 1'b1;
    #1;
    check("reset ready1 with req", 32'(ready_v[1]), 32'd1);
    @(negedge clk);
    rst = 1'b0; rd_en_v[1] = 1'b0;
    @(negedge clk);
    check("idle ready", 32'(ready_v[1]), 32'd1);
    check("idle we_n", 32'(we_n_v[1]), 32'd1);
    check("idle oe", 32'(oe_v[1]), 32'd0);
    check("idle read_data", rdata_v[1], 32'd0);
    check("idle sram_addr", 32'(saddr_v[1]), 32'd0);
    check("idle dq_out", 32'(dout_v[1]), 32'd0);

    // Table-driven word accesses on the default-timing instance.
    for (int i = 0; i < 7; i++) begin
      logic [17:0] hi_a;
      do_req(1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].lat, vecs[i].exp_rd, $sformatf("vec%0d", i));
      if (vecs[i].wr) begin
        hi_a = vecs[i].lo + 18'd1;
        check($sformatf("vec%0d mem lo", i), 32'(mem1[vecs[i].lo]), 32'(vecs[i].wdata[15:0]));
        check($sformatf("vec%0d mem hi", i), 32'(mem1[hi_a]), 32'(vecs[i].wdata[31:16]));
      end
    end

    // Reset during the high-half write phase.
    @(negedge clk);
    address = 32'd1040; write_data = 32'hA5A55A5A; wr_en_v[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst we_n in ACC_HI", 32'(we_n_v[1]), 32'd0);
    rst = 1'b1; wr_en_v[1] = 1'b0;
    @(negedge clk);
    check("midrst we_n", 32'(we_n_v[1]), 32'd1);
    check("midrst oe", 32'(oe_v[1]), 32'd0);
    check("midrst sram_addr", 32'(saddr_v[1]), 32'd0);
    check("midrst read_data", rdata_v[1], 32'd0);
    check("midrst ready", 32'(ready_v[1]), 32'd1);
    rst = 1'b0;
    do_req(1, 1'b0, 1'b1, 32'd1040, 32'h0F0F1234, 5, 32'h00000000, "postrst wr");
    do_req(1, 1'b1, 1'b0, 32'd1040, 32'h00000000, 5, 32'h0F0F1234, "postrst rd");

    // Zero wait cycles: back-to-back accesses of 4 cycles each.
    do_req(0, 1'b0, 1'b1, 32'd1024, 32'h11112222, 3, 32'h00000000, "w0 wr1024");
    do_req(0, 1'b0, 1'b1, 32'd1032, 32'h33334444, 3, 32'h00000000, "w0 wr1032");
    do_req(0, 1'b1, 1'b0, 32'd1024, 32'h00000000, 3, 32'h11112222, "w0 rd1024");
    do_req(0, 1'b1, 1'b0, 32'd1032, 32'h00000000, 3, 32'h33334444, "w0 rd1032");

`ifdef SRAM_POSTED_WRITE_EN
    // Posted write immediately followed by a read that must wait for it.
    begin
      int  cyc;
      bit  seen;
      @(negedge clk);
      address = 32'd1024; write_data = 32'h0BADCAFE; wr_en_v[1] = 1'b1;
      #1;
      check("posted wr ready@0", 32'(ready_v[1]), 32'd1);
      @(negedge clk);
      wr_en_v[1] = 1'b0; rd_en_v[1] = 1'b1; write_data = 32'd0;
      #1;
      check("posted rd ready@1", 32'(ready_v[1]), 32'd0);
      cyc = 1; seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (ready_v[1]) seen = 1'b1;
      end
      rd_en_v[1] = 1'b0;
      check("posted rd done", 32'(seen), 32'd1);
      check("posted rd ready cycle", 32'(cyc), 32'd10);
      check("posted rd data", rdata_v[1], 32'h0BADCAFE);
    end
`endif

    @(negedge clk);
    check("strobe consistency", 32'(strobe_bad), 32'd0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
